sync_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request interface and a pipelined read response.
Memory is cleared by a sequential init state machine rather than a one-cycle reset loop, so it maps to block RAM.
Supports configurable read latency and a software-triggered re-clear.
Serves as the general data/instruction store of the processor, replacing fixed 32x8 storage.

---
 rtl/sync_ram_pkg.sv | 18 +
 rtl/sync_ram_rd_pipe.sv | 39 +++
 rtl/sync_ram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sync_ram_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the synchronous RAM controller.
package sync_ram_pkg;

  typedef enum logic {CLEAR, IDLE} state_e;

  // Widest data word the parity helper covers.
  localparam int PAR_MAX_W = 64;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Even parity bit: makes the total count of ones even (zero extension is harmless).
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// Optional extra read-response register stage (STAGES = 0 or 1).
module sync_ram_rd_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_vld  = in_vld;
    assign out_data = in_data;
  end else begin : g_stage
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
      vld_d  = in_vld;
      data_d = in_vld ? in_data : data_q;
    end

    always_ff @(posedge clk or posedge rst)
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;

    always_ff @(posedge clk)
      data_q <= data_d;

    assign out_vld  = vld_q;
    assign out_data = data_q;
  end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Single-port sync RAM with sequential clear FSM and RD_LAT-cycle read response.
// Define SYNC_RAM_PARITY_EN to store an even-parity bit per word and expose rsp_perr.
module sync_ram_ctrl
  import sync_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef SYNC_RAM_PARITY_EN
  output logic              rsp_perr,
`endif
  output logic              busy,
  output logic              addr_err
);

`ifdef SYNC_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("sync_ram_ctrl: RD_LAT must be 1 or 2");
  end

  logic [MEM_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              addr_err_q, addr_err_d;
  logic              rd_vld_q, rd_vld_d;
  logic [MEM_W-1:0]  rd_data_q, rd_data_d;

  logic              acc, in_rng, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword, mem_rword, rd_word;

  assign req_ready = (state_q == IDLE) && !clr_req;
  assign busy      = (state_q == CLEAR);
  assign acc       = req_valid && req_ready;
  assign in_rng    = {1'b0, req_addr} < DEPTH_V;
  assign mem_rword = mem[req_addr];

`ifdef SYNC_RAM_PARITY_EN
  // Top bit of the response word flags a stored-parity mismatch.
  assign rd_word = {mem_rword[DATA_W] ^ even_par(PAR_MAX_W'(mem_rword[DATA_W-1:0])),
                    mem_rword[DATA_W-1:0]};
`else
  assign rd_word = mem_rword;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q | (acc && !in_rng);
    rd_vld_d   = acc && !req_we;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_waddr  = req_addr;
`ifdef SYNC_RAM_PARITY_EN
    mem_wword  = {even_par(PAR_MAX_W'(req_wdata)), req_wdata};
`else
    mem_wword  = req_wdata;
`endif
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wword = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (acc && req_we && in_rng) begin
          mem_we = 1'b1;
        end
      end
    endcase
    // Out-of-range reads still respond, with an all-zero word.
    if (acc && !req_we) rd_data_d = in_rng ? rd_word : '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end

  // Array has no reset so it maps onto block RAM; the CLEAR sequence zeroes it.
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wword;

  logic [MEM_W-1:0] pipe_data;

  sync_ram_rd_pipe #(.W(MEM_W), .STAGES(RD_LAT - 1)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_vld_q),
    .in_data (rd_data_q),
    .out_vld (rsp_valid),
    .out_data(pipe_data)
  );

  assign rsp_rdata = pipe_data[DATA_W-1:0];
`ifdef SYNC_RAM_PARITY_EN
  assign rsp_perr  = pipe_data[DATA_W];
`endif
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed bench: u0 (DEPTH 32, RD_LAT 1), u1 (DEPTH 32, RD_LAT 2), u2 (DEPTH 20, RD_LAT 1) on shared inputs.
module tb_sync_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0, req_valid = 1'b0, req_we = 1'b0, en2 = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic rdy0, rdy1, rdy2, v0, v1, v2, busy0, busy1, busy2, ae0, ae1, ae2;
  logic [7:0] d0, d1, d2;
`ifdef SYNC_RAM_PARITY_EN
  logic pe0, pe1, pe2;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v0), .rsp_rdata(d0),
`ifdef SYNC_RAM_PARITY_EN
    .rsp_perr(pe0),
`endif
    .busy(busy0), .addr_err(ae0));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1), .rsp_rdata(d1),
`ifdef SYNC_RAM_PARITY_EN
    .rsp_perr(pe1),
`endif
    .busy(busy1), .addr_err(ae1));

  sync_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RD_LAT(1)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid && en2), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v2), .rsp_rdata(d2),
`ifdef SYNC_RAM_PARITY_EN
    .rsp_perr(pe2),
`endif
    .busy(busy2), .addr_err(ae2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic we, input logic [4:0] a, input logic [7:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
  endtask

  // Drive inputs at a negedge and return at the next negedge (one posedge later).
  task automatic step(input logic v, input logic we, input logic [4:0] a, input logic [7:0] d);
    set_in(v, we, a, d);
    @(negedge clk);
  endtask

  // Count negedges until u0 leaves CLEAR, bounded.
  task automatic wait_clear(input string tag, input int exp);
    int n = 0;
    while (busy0 && n < 40) begin
      n++;
      step(1'b0, 1'b0, 5'd0, 8'd0);
    end
    chk(tag, n, exp);
  endtask

  initial begin
    int t0, t2, c0, c1, nz, ok0, ok1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_valid", v0, 1'b0);
    chk("rst_rdata", d0, 8'h00);
    chk("rst_addr_err", ae0, 1'b0);

    // Clear duration: 32 cycles for DEPTH 32, 20 for DEPTH 20.
    rst = 1'b0;
    t0 = 0; t2 = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (!busy0 && t0 == 0) t0 = k;
      if (!busy2 && t2 == 0) t2 = k;
    end
    chk("clr_time32", t0, 32);
    chk("clr_time20", t2, 20);
    chk("idle_ready", rdy0, 1'b1);

    // Every word reads back zero after the clear.
    c0 = 0; c1 = 0; nz = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'(i), 8'd0);
      if (v0) c0++;
      if (v1) c1++;
      if (d0 != 8'h00 || d1 != 8'h00) nz++;
    end
    step(1'b0, 1'b0, 5'd0, 8'd0);
    if (v1) c1++;
    chk("clr_rd_cnt_l1", c0, 32);
    chk("clr_rd_cnt_l2", c1, 32);
    chk("clr_rd_zero", nz, 0);

    // Write then read the same address on the next cycle.
    step(1'b1, 1'b1, 5'd3, 8'hA5);
    chk("wr_no_rsp", v0, 1'b0);
    step(1'b1, 1'b0, 5'd3, 8'd0);
    chk("war_l1_vld", v0, 1'b1);
    chk("war_l1_data", d0, 8'hA5);
    chk("war_l2_early", v1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 8'd0);
    chk("war_l1_drop", v0, 1'b0);
    chk("war_l1_hold", d0, 8'hA5);
    chk("war_l2_vld", v1, 1'b1);
    chk("war_l2_data", d1, 8'hA5);

    // Back-to-back reads stream out in order.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 5'(i), 8'(8'h10 + i));
    ok0 = 0; ok1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'(i), 8'd0);
      if (v0 && d0 == 8'(8'h10 + i)) ok0++;
      if (i > 0 && v1 && d1 == 8'(8'h10 + i - 1)) ok1++;
    end
    step(1'b0, 1'b0, 5'd0, 8'd0);
    if (v1 && d1 == 8'h17) ok1++;
    chk("tput_l1", ok0, 8);
    chk("tput_l2", ok1, 8);

    // Re-clear with a read still in flight in the RD_LAT 2 instance.
    step(1'b1, 1'b1, 5'd5, 8'hFF);
    step(1'b1, 1'b0, 5'd5, 8'd0);
    chk("pre_clr_l1", d0, 8'hFF);
    clr_req = 1'b1;
    set_in(1'b1, 1'b0, 5'd5, 8'd0);
    #1;
    chk("clr_ready_low", rdy0, 1'b0);
    @(negedge clk);
    clr_req = 1'b0;
    chk("clr_req_rejected", v0, 1'b0);
    chk("inflight_vld", v1, 1'b1);
    chk("inflight_data", d1, 8'hFF);
    wait_clear("reclr_time", 32);
    step(1'b1, 1'b0, 5'd5, 8'd0);
    chk("reclr_rd_vld", v0, 1'b1);
    chk("reclr_rd_data", d0, 8'h00);
    step(1'b0, 1'b0, 5'd0, 8'd0);

    // Reset at clear cycle 10 restarts the full clear.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b0, 1'b0, 5'd0, 8'd0);
    chk("midclr_busy", busy0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midclr_rst_ready", rdy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_clear("midclr_restart", 32);

    // Reset one cycle after a read accept discards in-flight responses.
    step(1'b1, 1'b1, 5'd3, 8'hA5);
    step(1'b1, 1'b0, 5'd3, 8'd0);
    chk("midrd_l1_vld", v0, 1'b1);
    set_in(1'b0, 1'b0, 5'd0, 8'd0);
    rst = 1'b1;
    #1;
    chk("midrd_rst_vld", v0, 1'b0);
    chk("midrd_rst_data", d0, 8'h00);
    c1 = 0;
    repeat (2) begin
      @(negedge clk);
      if (v1) c1++;
    end
    chk("midrd_l2_drop", c1, 0);
    rst = 1'b0;
    wait_clear("midrd_reclr", 32);

    // Range check on the DEPTH 20 instance.
    en2 = 1'b1;
    chk("rng_err_init", ae2, 1'b0);
    step(1'b1, 1'b1, 5'd5, 8'h55);
    step(1'b1, 1'b1, 5'd25, 8'h77);
    chk("rng_err_set", ae2, 1'b1);
    chk("rng_err_inrng", ae0, 1'b0);
    step(1'b1, 1'b0, 5'd25, 8'd0);
    chk("rng_rd_vld", v2, 1'b1);
    chk("rng_rd_zero", d2, 8'h00);
    chk("rng_rd_d32", d0, 8'h77);
    step(1'b1, 1'b0, 5'd5, 8'd0);
    chk("rng_alias", d2, 8'h55);
    step(1'b0, 1'b0, 5'd0, 8'd0);
    chk("rng_err_sticky", ae2, 1'b1);

`ifdef SYNC_RAM_PARITY_EN
    step(1'b1, 1'b0, 5'd5, 8'd0);
    chk("par_clean", pe0, 1'b0);
    u0.mem[5] = u0.mem[5] ^ 9'h001;
    step(1'b1, 1'b0, 5'd5, 8'd0);
    chk("par_flip", pe0, 1'b1);
    step(1'b1, 1'b0, 5'd25, 8'd0);
    chk("par_oor", pe2, 1'b0);
    step(1'b0, 1'b0, 5'd0, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
